// File: rtl/axi3_wr_arbiter_pkg.sv
// axi3_pkg: shared AXI3 burst/response encodings, arbiter state type and field widths.
package axi3_pkg;
  localparam int AXI3_LEN_W = 4;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} arb_state_t;
endpackage

// File: rtl/axi3_wr_arbiter_if.sv
// axi3_wr_arbiter_if: AXI3 write channels (AW/W/B) with master and slave modports.
interface axi3_wr_arbiter_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic [ADDR_W-1:0]                AWADDR;
  logic [axi3_pkg::AXI3_LEN_W-1:0]  AWLEN;
  logic [2:0]                       AWSIZE;
  logic [1:0]                       AWBURST;
  logic                             AWVALID;
  logic                             AWREADY;
  logic [DATA_W-1:0]                WDATA;
  logic [DATA_W/8-1:0]              WSTRB;
  logic                             WLAST;
  logic                             WVALID;
  logic                             WREADY;
  logic [1:0]                       BRESP;
  logic                             BVALID;
  logic                             BREADY;
  modport master (
    output AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, input AWREADY,
    output WDATA, WSTRB, WLAST, WVALID, input WREADY,
    input BRESP, BVALID, output BREADY
  );
  modport slave (
    input AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, output AWREADY,
    input WDATA, WSTRB, WLAST, WVALID, output WREADY,
    output BRESP, BVALID, input BREADY
  );
endinterface

// File: rtl/axi3_wr_arbiter_rr_arb2.sv
// axi3_rr_arb2: two-way round-robin picker; on a tie the master that was not granted last wins.
module axi3_rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic [1:0] pick_o
);
  always_comb pick_o = &req_i ? (last_grant_i ? 2'b01 : 2'b10) : req_i;
endmodule

// File: rtl/axi3_wr_arbiter.sv
// axi3_wr_arbiter: 2:1 AXI3 write-channel arbiter, grant held from AW through B.
// AXI_WR_ARB_TIMEOUT_EN adds a B watchdog returning SLVERR and absorbs late slave responses in IDLE.
module axi3_wr_arbiter
  import axi3_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  axi3_wr_arbiter_if.slave  m0,
  axi3_wr_arbiter_if.slave  m1,
  axi3_wr_arbiter_if.master s,
  output logic [1:0]        grant,
  output logic              err_wlast
);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
`ifdef AXI_WR_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  arb_state_t            state_q, state_d;
  logic [1:0]            grant_q, grant_d, pick, b_resp;
  logic                  last_q, last_d, err_q, err_d;
  logic [AXI3_LEN_W-1:0] len_q, len_d, beat_q, beat_d;
  logic [TO_W-1:0]       to_q, to_d;
  logic                  sel, in_addr, in_data, in_resp, to_hit, b_vld, b_hs, m_bready, last_beat;
  logic [ADDR_W-1:0]     aw_addr;
  logic [DATA_W-1:0]     w_data;
  logic [DATA_W/8-1:0]   w_strb;
  assign sel       = grant_q[1];
  assign in_addr   = state_q == ADDR;
  assign in_data   = state_q == DATA;
  assign in_resp   = state_q == RESP;
  assign aw_addr   = sel ? m1.AWADDR : m0.AWADDR;
  assign w_data    = sel ? m1.WDATA : m0.WDATA;
  assign w_strb    = sel ? m1.WSTRB : m0.WSTRB;
  assign m_bready  = sel ? m1.BREADY : m0.BREADY;
  assign last_beat = beat_q == len_q;
  // Once the watchdog fires the block owns the B channel; the slave response is ignored.
  assign to_hit    = TO_EN && in_resp && to_q == TO_W'(TIMEOUT_CYCLES);
  assign b_vld     = s.BVALID | to_hit;
  assign b_resp    = to_hit ? RESP_SLVERR : s.BRESP;
  assign b_hs      = in_resp & b_vld & m_bready;
  assign grant     = grant_q;
  assign err_wlast = err_q;
  axi3_rr_arb2 u_arb (
    .req_i       ({m1.AWVALID, m0.AWVALID}),
    .last_grant_i(last_q),
    .pick_o      (pick)
  );
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      last_q  <= 1'b1;
      len_q   <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
      to_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
      to_q    <= to_d;
    end
  end
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    len_d   = len_q;
    beat_d  = beat_q;
    err_d   = err_q;
    to_d    = (TO_EN && in_resp && !s.BVALID && !to_hit) ? to_q + 1'b1 : (in_resp ? to_q : '0);
    case (state_q)
      IDLE: if (|pick) begin
        grant_d = pick;
        state_d = ADDR;
      end
      ADDR: if (s.AWVALID && s.AWREADY) begin
        len_d   = s.AWLEN;
        beat_d  = '0;
        state_d = DATA;
      end
      DATA: if (s.WVALID && s.WREADY) begin
        beat_d  = beat_q + 1'b1;
        err_d   = err_q | (s.WLAST != last_beat);
        state_d = last_beat ? RESP : DATA;
      end
      RESP: if (b_hs) begin
        last_d  = grant_q[1];
        grant_d = 2'b00;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    s.AWVALID  = in_addr & (sel ? m1.AWVALID : m0.AWVALID);
    s.AWADDR   = in_addr ? aw_addr : '0;
    s.AWLEN    = in_addr ? (sel ? m1.AWLEN : m0.AWLEN) : '0;
    s.AWSIZE   = in_addr ? (sel ? m1.AWSIZE : m0.AWSIZE) : '0;
    s.AWBURST  = in_addr ? (sel ? m1.AWBURST : m0.AWBURST) : '0;
    s.WVALID   = in_data & (sel ? m1.WVALID : m0.WVALID);
    s.WDATA    = in_data ? w_data : '0;
    s.WSTRB    = in_data ? w_strb : '0;
    s.WLAST    = in_data & (sel ? m1.WLAST : m0.WLAST);
    s.BREADY   = (in_resp & ~to_hit & m_bready) | (TO_EN & (state_q == IDLE) & ARESETn);
    m0.AWREADY = in_addr & grant_q[0] & s.AWREADY;
    m0.WREADY  = in_data & grant_q[0] & s.WREADY;
    m0.BVALID  = in_resp & grant_q[0] & b_vld;
    m0.BRESP   = (in_resp & grant_q[0]) ? b_resp : RESP_OKAY;
    m1.AWREADY = in_addr & grant_q[1] & s.AWREADY;
    m1.WREADY  = in_data & grant_q[1] & s.WREADY;
    m1.BVALID  = in_resp & grant_q[1] & b_vld;
    m1.BRESP   = (in_resp & grant_q[1]) ? b_resp : RESP_OKAY;
  end
endmodule

// File: tb/tb_axi3_wr_arbiter.sv
// tb_axi3_wr_arbiter: scoreboard bench; masters queue expected slave-side AW/W beats and grant order.
module tb_axi3_wr_arbiter;
  import axi3_pkg::*;
  logic ACLK = 1'b0, ARESETn = 1'b0;
  logic [1:0] grant;
  logic err_wlast;
  axi3_wr_arbiter_if m0i (), m1i (), si ();
  axi3_wr_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .m0(m0i), .m1(m1i), .s(si), .grant(grant), .err_wlast(err_wlast)
  );
  always #5 ACLK = ~ACLK;
  int n_chk = 0, n_pass = 0;
  logic [40:0] aw_q0[$], aw_q1[$];
  logic [36:0] w_q0[$], w_q1[$];
  logic [1:0]  gq[$];
  int aw_delay = 0, aw_wait = 0, beats = 0;
  bit w_toggle = 0, no_b = 0, stray = 0, b_pend = 0, aw_f = 0, w_f = 0, b_f = 0;
  logic [1:0] slv_resp = RESP_OKAY, cur_g = 2'b00;
  logic [3:0] len_f = 4'd0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic set_aw(input int id, input logic v, input logic [31:0] a, input logic [3:0] l);
    if (id == 0) begin
      m0i.AWVALID = v; m0i.AWADDR = a; m0i.AWLEN = l; m0i.AWSIZE = 3'd2; m0i.AWBURST = BURST_INCR;
    end else begin
      m1i.AWVALID = v; m1i.AWADDR = a; m1i.AWLEN = l; m1i.AWSIZE = 3'd2; m1i.AWBURST = BURST_INCR;
    end
  endtask
  task automatic set_w(input int id, input logic v, input logic [31:0] d, input logic l);
    if (id == 0) begin
      m0i.WVALID = v; m0i.WDATA = d; m0i.WLAST = l; m0i.WSTRB = 4'hF;
    end else begin
      m1i.WVALID = v; m1i.WDATA = d; m1i.WLAST = l; m1i.WSTRB = 4'hF;
    end
  endtask
  function automatic logic rdy(input int id, input int kind);
    if (kind == 0) return id == 0 ? m0i.AWREADY : m1i.AWREADY;
    if (kind == 1) return id == 0 ? m0i.WREADY : m1i.WREADY;
    return id == 0 ? m0i.BVALID : m1i.BVALID;
  endfunction
  task automatic wait_rdy(input int id, input int kind, input string tag);
    int t = 0;
    do begin
      @(negedge ACLK); #2;
      t++;
    end while (!rdy(id, kind) && t < 400);
    if (!rdy(id, kind)) chk(tag, rdy(id, kind), 1);
  endtask
  task automatic mtx(input int id, input logic [31:0] a, input logic [3:0] l,
                     input logic [31:0] base, input bit bad_last, input logic [1:0] exp_resp);
    logic wl;
    @(posedge ACLK); #1;
    if (id == 0) aw_q0.push_back({a, l, 3'd2, BURST_INCR});
    else aw_q1.push_back({a, l, 3'd2, BURST_INCR});
    for (int i = 0; i <= int'(l); i++) begin
      wl = bad_last ? (i == 0) : (i == int'(l));
      if (id == 0) w_q0.push_back({4'hF, wl, base + 32'(i)});
      else w_q1.push_back({4'hF, wl, base + 32'(i)});
    end
    set_aw(id, 1'b1, a, l);
    wait_rdy(id, 0, "aw_timeout");
    @(posedge ACLK); #1;
    set_aw(id, 1'b0, 32'h0, 4'h0);
    for (int i = 0; i <= int'(l); i++) begin
      set_w(id, 1'b1, base + 32'(i), bad_last ? (i == 0) : (i == int'(l)));
      wait_rdy(id, 1, "w_timeout");
      @(posedge ACLK); #1;
    end
    set_w(id, 1'b0, 32'h0, 1'b0);
    if (id == 0) m0i.BREADY = 1'b1; else m1i.BREADY = 1'b1;
    wait_rdy(id, 2, "b_timeout");
    chk("bresp", id == 0 ? m0i.BRESP : m1i.BRESP, exp_resp);
    @(posedge ACLK); #1;
    if (id == 0) m0i.BREADY = 1'b0; else m1i.BREADY = 1'b0;
  endtask
  // Slave model and monitor: flags computed at negedge+1 describe the handshakes of the next posedge.
  initial begin
    logic [40:0] ea;
    logic [36:0] ew;
    forever begin
      @(negedge ACLK);
      if (aw_f) begin aw_wait = 0; beats = int'(len_f) + 1; end
      if (w_f) begin beats--; if (beats == 0) b_pend = 1; end
      if (b_f) b_pend = 0;
      si.AWREADY = si.AWVALID && (aw_wait >= aw_delay);
      if (si.AWVALID && !si.AWREADY) aw_wait++;
      si.WREADY = w_toggle ? !si.WREADY : 1'b1;
      si.BVALID = b_pend && !no_b;
      si.BRESP = slv_resp;
      #1;
      aw_f = si.AWVALID && si.AWREADY;
      w_f = si.WVALID && si.WREADY;
      b_f = si.BVALID && si.BREADY;
      len_f = si.AWLEN;
      if (aw_f) begin
        chk("gq_size", gq.size(), gq.size() == 0 ? 1 : gq.size());
        if (gq.size() != 0) chk("aw_grant", grant, gq.pop_front());
        cur_g = grant;
        if (grant[1]) begin
          chk("aw_q1_size", aw_q1.size() != 0, 1);
          if (aw_q1.size() != 0) begin ea = aw_q1.pop_front(); chk("aw_m1", {si.AWADDR, si.AWLEN, si.AWSIZE, si.AWBURST}, ea); end
        end else begin
          chk("aw_q0_size", aw_q0.size() != 0, 1);
          if (aw_q0.size() != 0) begin ea = aw_q0.pop_front(); chk("aw_m0", {si.AWADDR, si.AWLEN, si.AWSIZE, si.AWBURST}, ea); end
        end
      end
      if (w_f) begin
        chk("w_grant", grant, cur_g);
        if (grant[1]) begin
          chk("w_q1_size", w_q1.size() != 0, 1);
          if (w_q1.size() != 0) begin ew = w_q1.pop_front(); chk("w_m1", {si.WSTRB, si.WLAST, si.WDATA}, ew); end
        end else begin
          chk("w_q0_size", w_q0.size() != 0, 1);
          if (w_q0.size() != 0) begin ew = w_q0.pop_front(); chk("w_m0", {si.WSTRB, si.WLAST, si.WDATA}, ew); end
        end
      end
      if (b_f && !stray) chk("b_grant", grant, cur_g);
      if (grant == 2'b01) chk("m1_quiet", {m1i.AWREADY, m1i.WREADY, m1i.BVALID}, 3'b000);
      if (grant == 2'b10) chk("m0_quiet", {m0i.AWREADY, m0i.WREADY, m0i.BVALID}, 3'b000);
    end
  end
  initial begin
    set_aw(0, 1'b0, 32'h0, 4'h0); set_aw(1, 1'b0, 32'h0, 4'h0);
    set_w(0, 1'b0, 32'h0, 1'b0); set_w(1, 1'b0, 32'h0, 1'b0);
    m0i.BREADY = 1'b0; m1i.BREADY = 1'b0;
    si.AWREADY = 1'b0; si.WREADY = 1'b0; si.BVALID = 1'b0; si.BRESP = RESP_OKAY;
    repeat (2) @(negedge ACLK);
    #1;
    chk("rst_grant", grant, 2'b00);
    chk("rst_err", err_wlast, 1'b0);
    chk("rst_s_ctl", {si.AWVALID, si.WVALID, si.WLAST, si.BREADY}, 4'b0000);
    chk("rst_s_payload", {si.AWADDR, si.AWLEN, si.WDATA, si.WSTRB}, 64'h0);
    chk("rst_m_ctl", {m0i.AWREADY, m0i.WREADY, m0i.BVALID, m1i.AWREADY, m1i.WREADY, m1i.BVALID}, 6'b0);
    @(posedge ACLK); #1;
    ARESETn = 1'b1;
    gq.push_back(2'b01); gq.push_back(2'b10);
    fork
      mtx(0, 32'h20, 4'd0, 32'h100, 1'b0, RESP_OKAY);
      mtx(1, 32'h30, 4'd0, 32'h200, 1'b0, RESP_OKAY);
    join
    gq.push_back(2'b01);
    mtx(0, 32'h0, 4'd0, 32'hDEADBEEF, 1'b0, RESP_OKAY);
    chk("grant_idle", grant, 2'b00);
    gq.push_back(2'b10); gq.push_back(2'b01);
    fork
      mtx(0, 32'h24, 4'd0, 32'h300, 1'b0, RESP_OKAY);
      mtx(1, 32'h34, 4'd0, 32'h400, 1'b0, RESP_OKAY);
    join
    gq.push_back(2'b10);
    mtx(1, 32'h40, 4'd3, 32'h1, 1'b0, RESP_OKAY);
    chk("burst_err", err_wlast, 1'b0);
    gq.push_back(2'b01);
    mtx(0, 32'h50, 4'd1, 32'h10, 1'b1, RESP_OKAY);
    chk("wlast_err", err_wlast, 1'b1);
    aw_delay = 3; w_toggle = 1; slv_resp = RESP_SLVERR;
    gq.push_back(2'b10);
    mtx(1, 32'h60, 4'd2, 32'hA0, 1'b0, RESP_SLVERR);
    aw_delay = 0; w_toggle = 0; slv_resp = RESP_OKAY;
    chk("err_sticky", err_wlast, 1'b1);
`ifdef AXI_WR_ARB_TIMEOUT_EN
    no_b = 1;
    gq.push_back(2'b01);
    mtx(0, 32'h70, 4'd0, 32'h77, 1'b0, RESP_SLVERR);
    stray = 1; no_b = 0;
    repeat (3) @(negedge ACLK);
    #3;
    chk("stray_absorbed", b_pend, 1'b0);
    stray = 0;
    gq.push_back(2'b10);
    mtx(1, 32'h80, 4'd0, 32'h88, 1'b0, RESP_OKAY);
`endif
    repeat (2) @(negedge ACLK);
    chk("queues_drained", aw_q0.size() + aw_q1.size() + w_q0.size() + w_q1.size() + gq.size(), 0);
    ARESETn = 1'b0;
    #1;
    chk("err_cleared", err_wlast, 1'b0);
    chk("grant_cleared", grant, 2'b00);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/axi3_wr_arbiter.md
Name: axi3_wr_arbiter

Overview:
Two-master to one-slave AXI3 write-channel arbiter (AW/W/B only) that shares one slave port, such as the memory or the AXI-to-APB bridge, between the RISC-V master and the DMA master. It grants one master per transaction using round-robin and holds the grant from the AW handshake through the B handshake. It routes W and B to the granted master only. It is the per-slave arbitration stage of axi3_interconnect.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; STRB width = DATA_W/8
TIMEOUT_CYCLES, 256, B-response watchdog limit (used only with AXI_WR_ARB_TIMEOUT_EN)

Ports:
ACLK  in  1  clock
ARESETn  in  1  asynchronous active-low reset
Mn_AWADDR/AWLEN/AWSIZE/AWBURST  in  ADDR_W/4/3/2  n=0,1; master AW payload
Mn_AWVALID  in  1  master address valid
Mn_AWREADY  out  1  address ready to master
Mn_WDATA/WSTRB/WLAST/WVALID  in  DATA_W/DATA_W/8/1/1  master write data
Mn_WREADY  out  1  write ready to master
Mn_BRESP/BVALID  out  2/1  response to master
Mn_BREADY  in  1  master response ready
S_AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID  out  ADDR_W/4/3/2/1  slave AW
S_AWREADY  in  1  slave address ready
S_WDATA/WSTRB/WLAST/WVALID  out  DATA_W/DATA_W/8/1/1  slave W
S_WREADY  in  1  slave write ready
S_BRESP/BVALID  in  2/1  slave response
S_BREADY  out  1  response ready to slave
grant  out  2  one-hot active grant; 00 when idle
err_wlast  out  1  sticky: WLAST position did not match AWLEN

Behaviour:
- Reset ARESETn is asynchronous and active-low; clock is ACLK. In reset: state=IDLE, grant=00, last_grant=M1 (so M0 wins the first tie), beat_cnt=0, err_wlast=0. Every READY/VALID output is 0 and every slave payload output is 0.
- State machine: IDLE -> ADDR -> DATA -> RESP -> IDLE.
- IDLE
  - Sample M0_AWVALID and M1_AWVALID.
  - One requester: grant it. Both requesting: grant the master that is not last_grant.
  - The grant register is loaded on the clock edge, so the minimum latency from AWVALID to S_AWVALID is 1 cycle.
- ADDR
  - S_AW* = granted master's AW; granted Mn_AWREADY = S_AWREADY.
  - On the S_AWVALID&S_AWREADY handshake: latch AWLEN into len_q, clear beat_cnt, go to DATA.
- DATA
  - S_W* = granted master's W; granted Mn_WREADY = S_WREADY.
  - Each W handshake increments beat_cnt (4-bit).
  - The burst ends on the handshake where beat_cnt==len_q; go to RESP. Termination is by the counter, independent of WLAST.
  - If WLAST is asserted on a handshake where beat_cnt!=len_q, or deasserted on the final beat, set err_wlast. err_wlast clears only on reset.
- RESP
  - Granted Mn_BVALID/BRESP = S_BVALID/S_BRESP; S_BREADY = granted Mn_BREADY.
  - On the B handshake: last_grant <= grant, grant <= 00, go to IDLE.
- The non-granted master always sees AWREADY=WREADY=BVALID=0. Its requests wait and are never dropped.
- A master that loses arbitration on a tie wins the next tie (no starvation). Back-to-back transactions from one master need one IDLE cycle between them.
- Payload muxes are combinational from the registered grant. There is no combinational path from Mn_*VALID to Mn_*READY except through the slave's READY.
- Asserting ARESETn low mid-transaction aborts immediately to the reset values. No response is generated.

Optional Feature:
AXI_WR_ARB_TIMEOUT_EN
- Enabled:
  - In RESP, a counter counts cycles without S_BVALID.
  - At TIMEOUT_CYCLES the block drives the granted Mn_BVALID=1 with BRESP=2'b10 (SLVERR), holding S_BREADY=0.
  - On the master's B handshake it returns to IDLE.
  - In IDLE, S_BREADY=1 so a late slave BVALID is accepted and discarded.
- Disabled: RESP waits indefinitely, and S_BREADY=0 in IDLE.

Decomposition:
- Package axi3_pkg:
  - BURST_FIXED/INCR/WRAP constants
  - RESP_OKAY/EXOKAY/SLVERR/DECERR constants
  - arb_state_t enum {IDLE, ADDR, DATA, RESP}
  - AXI3_LEN_W=4
- Sub-module axi3_rr_arb2: 2-way round-robin picker. Inputs: req[1:0], last_grant. Output: one-hot pick. Combinational.

Test Plan:
- M0 single beat: AWADDR=0x0000_0000, AWLEN=0, WDATA=0xDEADBEEF; slave BRESP=00 -> grant=01; S_AWADDR=0x0; M0_BRESP=00; M1 sees no READY; grant returns to 00.
- Simultaneous: M0 AW=0x20 and M1 AW=0x30 in the same cycle after reset -> M0 served first, then M1. A second tie grants M1 first.
- Burst: M1 AWLEN=3, INCR, 4 beats 0x1..0x4, WLAST on beat 4 -> four S_W handshakes in order; RESP entered after the 4th; err_wlast=0.
- WLAST error: AWLEN=1 with WLAST on beat 1 -> err_wlast=1; transaction still completes after 2 beats; err_wlast stays 1 until reset.
- Backpressure: S_AWREADY delayed 3 cycles and S_WREADY toggling -> payload held stable; no beat lost or duplicated; grant held through B.
- (TIMEOUT_EN, TIMEOUT_CYCLES=16) slave never asserts BVALID -> M0_BVALID with BRESP=10 after 16 cycles in RESP. A later stray S_BVALID is absorbed in IDLE, and the next M1 transaction completes OKAY.
